// File: rtl/fetch_pair_sequencer_if.sv
// Fetch sequencer bundle: issue-side controls in, ROM controls and status out.
interface fetch_pair_sequencer_if;
    logic        fetch_en;
    logic [1:0]  consume;
    logic        branch_valid;
    logic [14:0] branch_target;
    logic [13:0] rom_addr;
    logic        pc_1;
    logic        sel_mem_1;
    logic [1:0]  sel_mem_0;
    logic        ir0_valid;
    logic        ir1_valid;
    logic [14:0] pc;
    logic        err;

    modport master (
        output fetch_en, consume, branch_valid, branch_target,
        input  rom_addr, pc_1, sel_mem_1, sel_mem_0,
        input  ir0_valid, ir1_valid, pc, err
    );

    modport slave (
        input  fetch_en, consume, branch_valid, branch_target,
        output rom_addr, pc_1, sel_mem_1, sel_mem_0,
        output ir0_valid, ir1_valid, pc, err
    );
endinterface

// File: rtl/fetch_pair_sequencer.sv
// Dual-issue fetch sequencer for the two-bank interleaved program ROM.
// Owns the instruction-index PC and steers bank/row selection.
module fetch_pair_sequencer #(
    parameter int PROG_LEN = 22
) (
    input  logic                          clk,
    input  logic                          rst_n,
    fetch_pair_sequencer_if.slave         bus
);
    localparam logic [15:0] LEN = 16'(PROG_LEN);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        REDIRECT,
        HALT
    } state_t;

    state_t      state, state_n;
    logic [14:0] pc_q, pc_n;
    logic        err_q, err_n;
    logic        v0, v1;
    logic [1:0]  slots, adv;
    logic [15:0] nxt;

    // Slot validity is computed in 16 bits so pc+1 never wraps.
    assign v0    = {1'b0, pc_q} < LEN;
    assign v1    = ({1'b0, pc_q} + 16'd1) < LEN;
    assign slots = {1'b0, v0} + {1'b0, v1};
    assign adv   = (bus.consume > slots) ? slots : bus.consume;
    assign nxt   = {1'b0, pc_q} + {14'd0, adv};

    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        err_n   = err_q;
        if (bus.branch_valid && state != IDLE) begin
            pc_n    = bus.branch_target;
            state_n = REDIRECT;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.fetch_en) state_n = FETCH;
                end
                FETCH: begin
                    if (bus.fetch_en) begin
                        pc_n = nxt[14:0];
                        if (bus.consume > slots) err_n = 1'b1;
                        if (nxt >= LEN) state_n = HALT;
                    end
                end
                REDIRECT: begin
                    state_n = v0 ? FETCH : HALT;
                end
                HALT: begin
                    state_n = HALT;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc_q  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            pc_q  <= pc_n;
            err_q <= err_n;
        end
    end

    // Odd pc: IR_0 from bank 1, IR_1 from bank 0 one row further.
    assign bus.rom_addr  = pc_q[14:1];
    assign bus.pc_1      = pc_q[0];
    assign bus.sel_mem_0 = pc_q[0] ? 2'd2 : 2'd0;
    assign bus.sel_mem_1 = ~pc_q[0];
    assign bus.ir0_valid = (state == FETCH) & bus.fetch_en & v0;
    assign bus.ir1_valid = (state == FETCH) & bus.fetch_en & v1;
    assign bus.pc        = pc_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_fetch_pair_sequencer.sv
// Scoreboarded bench for fetch_pair_sequencer: directed plan items then
// randomized traffic against a flag-based reference model.
module tb_fetch_pair_sequencer;
    localparam int LEN = 22;

    typedef struct packed {
        logic [14:0] pc;
        logic [13:0] ra;
        logic        p1;
        logic        s1;
        logic [1:0]  s0;
        logic        v0;
        logic        v1;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    fetch_pair_sequencer_if bus ();

    fetch_pair_sequencer #(.PROG_LEN(LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   vectors = 0;
    int   fails = 0;
    int   cyc = 0;

    // Reference model: started / in-bubble / halted flags plus an index.
    int   m_pc = 0;
    bit   m_run = 0;
    bit   m_bub = 0;
    bit   m_halt = 0;
    bit   m_err = 0;

    task automatic step(input bit rst, input bit en, input int cons,
                        input bit br, input int tgt);
        exp_t e;
        int   n;
        int   take;
        @(posedge clk);
        #1;
        if (rst) begin
            rst_n = 1'b0;
            m_pc = 0; m_run = 0; m_bub = 0; m_halt = 0; m_err = 0;
        end else begin
            rst_n = 1'b1;
        end
        bus.fetch_en      = en;
        bus.consume       = 2'(cons);
        bus.branch_valid  = br;
        bus.branch_target = 15'(tgt);
        n = 0;
        if (!rst && m_run && !m_bub && !m_halt && en)
            n = int'(m_pc < LEN) + int'(m_pc + 1 < LEN);
        e.pc  = 15'(m_pc);
        e.ra  = 14'(m_pc / 2);
        e.p1  = (m_pc % 2) == 1;
        e.s1  = (m_pc % 2) == 0;
        e.s0  = (m_pc % 2) == 1 ? 2'd2 : 2'd0;
        e.v0  = n >= 1;
        e.v1  = n >= 2;
        e.err = m_err;
        q.push_back(e);
        if (rst) return;
        if (br && m_run) begin
            m_pc = tgt; m_bub = 1; m_halt = 0;
        end else if (!m_run) begin
            m_run = en;
        end else if (m_bub) begin
            m_bub = 0;
            m_halt = m_pc >= LEN;
        end else if (!m_halt && en) begin
            take = cons < n ? cons : n;
            if (cons > n) m_err = 1;
            m_pc += take;
            m_halt = m_pc >= LEN;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {bus.pc, bus.rom_addr, bus.pc_1, bus.sel_mem_1,
                 bus.sel_mem_0, bus.ir0_valid, bus.ir1_valid, bus.err};
            vectors++;
            if (a !== e) begin
                fails++;
                $display("FAIL cyc%0d got pc=%0d ra=%0d p1=%b s1=%b s0=%0d v=%b%b err=%b exp pc=%0d ra=%0d p1=%b s1=%b s0=%0d v=%b%b err=%b",
                         cyc, a.pc, a.ra, a.p1, a.s1, a.s0, a.v0, a.v1, a.err,
                         e.pc, e.ra, e.p1, e.s1, e.s0, e.v0, e.v1, e.err);
            end
        end
    end

    initial begin
        int r;
        int cons;
        bus.fetch_en = 0; bus.consume = 0;
        bus.branch_valid = 0; bus.branch_target = 0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 1, 2, 0, 0);
        step(0, 1, 0, 1, 0);
        step(0, 1, 2, 0, 0);
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 2, 0, 0);
        step(0, 1, 2, 1, 7);
        for (int i = 0; i < 3; i++) step(0, 1, 2, 0, 0);
        step(0, 1, 0, 1, 4);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 2, 0, 0);
        step(0, 1, 2, 0, 0);
        step(0, 1, 0, 1, 20);
        step(0, 1, 0, 0, 0);
        step(0, 1, 2, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 21);
        step(0, 1, 0, 0, 0);
        step(0, 1, 2, 0, 0);
        step(0, 1, 2, 0, 0);
        step(0, 1, 0, 1, 9);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 1, 2, 1, 5);
        step(0, 1, 1, 1, 30);
        step(0, 1, 2, 0, 0);
        step(0, 1, 2, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            cons = ($urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, 2));
            step(r == 0, $urandom_range(0, 9) != 0, cons,
                 $urandom_range(0, 14) == 0, int'($urandom_range(0, LEN + 2)));
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            fails++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
